// File: rtl/con4_win_checker.sv
// Connect-4 win/draw detector: after each loaded piece, walks the board through a
// synchronous read port along the four axes through that piece and flags win or draw.
module con4_win_checker #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [1:0] piece,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic       draw,
  output logic [1:0] winner
);

  localparam int KW = $clog2(WIN_LEN + 1);
  localparam int TW = 6;
  localparam logic signed [TW-1:0] ROWS_S = 6'(ROWS);
  localparam logic signed [TW-1:0] COLS_S = 6'(COLS);
  localparam logic [KW-1:0] KLIM = KW'(WIN_LEN - 1);
  localparam logic [KW-1:0] WINC = KW'(WIN_LEN);
  localparam logic [KW-1:0] ONE_K = KW'(1);
  localparam logic [5:0] FULL = 6'(ROWS * COLS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AXIS = 3'd1,
    ST_STEP = 3'd2,
    ST_CMP  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Signed target {row, col} = base + k * delta(axis) * (neg ? -1 : +1).
  function automatic logic [2*TW-1:0] calc_tgt(
    input logic [2:0]    br,
    input logic [2:0]    bc,
    input logic [1:0]    ax,
    input logic [KW-1:0] k,
    input logic          neg
  );
    logic signed [TW-1:0] dr0, dc0, dr, dc, kk, tr, tc;
    kk = $signed({{(TW-KW){1'b0}}, k});
    case (ax)
      2'd0:    begin dr0 = 6'sd0; dc0 = 6'sd1;  end
      2'd1:    begin dr0 = 6'sd1; dc0 = 6'sd0;  end
      2'd2:    begin dr0 = 6'sd1; dc0 = 6'sd1;  end
      2'd3:    begin dr0 = 6'sd1; dc0 = -6'sd1; end
      default: begin dr0 = 6'sd0; dc0 = 6'sd0;  end
    endcase
    dr = neg ? -dr0 : dr0;
    dc = neg ? -dc0 : dc0;
    tr = $signed({3'b000, br}) + kk * dr;
    tc = $signed({3'b000, bc}) + kk * dc;
    return {tr, tc};
  endfunction

  // A cell is worth reading only when on the board and still within the line length.
  function automatic logic tgt_ok(input logic [2*TW-1:0] t, input logic [KW-1:0] k);
    logic signed [TW-1:0] tr, tc;
    tr = $signed(t[2*TW-1:TW]);
    tc = $signed(t[TW-1:0]);
    return (tr >= 6'sd0) && (tr < ROWS_S) && (tc >= 6'sd0) && (tc < COLS_S) && (k <= KLIM);
  endfunction

  state_t          state_r, state_n;
  logic [2:0]      row_r, col_r;
  logic [1:0]      piece_r;
  logic [1:0]      axis_r, axis_n;
  logic [KW-1:0]   k_r, k_n;
  logic            dir_r, dir_n;
  logic [KW-1:0]   cnt_r, cnt_n;
  logic [5:0]      pcnt_r;
  logic            busy_r, done_r, win_r, draw_r;
  logic [1:0]      winner_r;
  logic [2:0]      rd_row_r, rd_col_r, rd_row_n, rd_col_n;
  logic [2*TW-1:0] cur_tgt_s, nxt_tgt_s;
  logic            cur_ok_s, match_s, last_axis_s, accept_s, bad_s;

  assign accept_s = start && !busy_r && !win_r && !draw_r;
  assign bad_s    = ({1'b0, row} >= 4'(ROWS)) || ({1'b0, col} >= 4'(COLS)) ||
                    !((piece == 2'b01) || (piece == 2'b10));

  // Next-state logic; the read address is precomputed so it is registered on entry to STEP.
  always_comb begin
    state_n     = state_r;
    axis_n      = axis_r;
    k_n         = k_r;
    dir_n       = dir_r;
    cnt_n       = cnt_r;
    rd_row_n    = 3'd0;
    rd_col_n    = 3'd0;
    cur_tgt_s   = calc_tgt(row_r, col_r, axis_r, k_r, dir_r);
    cur_ok_s    = tgt_ok(cur_tgt_s, k_r);
    match_s     = (rd_data == piece_r);
    last_axis_s = (axis_r == 2'd3);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          axis_n  = 2'd0;
          cnt_n   = '0;
          state_n = bad_s ? ST_FIN : ST_AXIS;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_AXIS: begin
        cnt_n   = ONE_K;
        k_n     = ONE_K;
        dir_n   = 1'b0;
        state_n = ST_STEP;
      end
      ST_STEP: begin
        if (cur_ok_s) begin
          state_n = ST_CMP;
        end else if (!dir_r) begin
          dir_n   = 1'b1;
          k_n     = ONE_K;
          state_n = ST_STEP;
        end else if (last_axis_s) begin
          state_n = ST_FIN;
        end else begin
          axis_n  = axis_r + 2'd1;
          state_n = ST_AXIS;
        end
      end
      ST_CMP: begin
        if (match_s) begin
          cnt_n   = cnt_r + ONE_K;
          k_n     = k_r + ONE_K;
          state_n = ((cnt_r + ONE_K) == WINC) ? ST_FIN : ST_STEP;
        end else if (!dir_r) begin
          dir_n   = 1'b1;
          k_n     = ONE_K;
          state_n = ST_STEP;
        end else if (last_axis_s) begin
          state_n = ST_FIN;
        end else begin
          axis_n  = axis_r + 2'd1;
          state_n = ST_AXIS;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    nxt_tgt_s = calc_tgt(row_r, col_r, axis_n, k_n, dir_n);
    if (((state_n == ST_STEP) || (state_n == ST_CMP)) && tgt_ok(nxt_tgt_s, k_n)) begin
      rd_row_n = nxt_tgt_s[TW+2:TW];
      rd_col_n = nxt_tgt_s[2:0];
    end else begin
      rd_row_n = 3'd0;
      rd_col_n = 3'd0;
    end
  end

  // State, datapath and sticky result registers; clear behaves like reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      row_r    <= 3'd0;
      col_r    <= 3'd0;
      piece_r  <= 2'b00;
      axis_r   <= 2'd0;
      k_r      <= '0;
      dir_r    <= 1'b0;
      cnt_r    <= '0;
      pcnt_r   <= 6'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      win_r    <= 1'b0;
      draw_r   <= 1'b0;
      winner_r <= 2'b00;
      rd_row_r <= 3'd0;
      rd_col_r <= 3'd0;
    end else if (clear) begin
      state_r  <= ST_IDLE;
      row_r    <= 3'd0;
      col_r    <= 3'd0;
      piece_r  <= 2'b00;
      axis_r   <= 2'd0;
      k_r      <= '0;
      dir_r    <= 1'b0;
      cnt_r    <= '0;
      pcnt_r   <= 6'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      win_r    <= 1'b0;
      draw_r   <= 1'b0;
      winner_r <= 2'b00;
      rd_row_r <= 3'd0;
      rd_col_r <= 3'd0;
    end else begin
      state_r  <= state_n;
      axis_r   <= axis_n;
      k_r      <= k_n;
      dir_r    <= dir_n;
      cnt_r    <= cnt_n;
      rd_row_r <= rd_row_n;
      rd_col_r <= rd_col_n;
      done_r   <= (state_r == ST_FIN);
      if ((state_r == ST_IDLE) && accept_s) begin
        row_r   <= row;
        col_r   <= col;
        piece_r <= piece;
        busy_r  <= 1'b1;
        if (!bad_s && (pcnt_r != FULL)) begin
          pcnt_r <= pcnt_r + 6'd1;
        end
      end else if (state_r == ST_FIN) begin
        busy_r <= 1'b0;
        if (cnt_r == WINC) begin
          win_r    <= 1'b1;
          winner_r <= piece_r;
        end else if (pcnt_r == FULL) begin
          draw_r <= 1'b1;
        end
      end
    end
  end

  assign rd_row = rd_row_r;
  assign rd_col = rd_col_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign win    = win_r;
  assign draw   = draw_r;
  assign winner = winner_r;

endmodule

// File: tb/tb_con4_win_checker.sv
// Directed bench for con4_win_checker: behavioural board RAM with one-cycle read
// latency, hand-computed latencies and results for each scenario.
module tb_con4_win_checker;

  logic       clk = 1'b0;
  logic       rst, clear, start;
  logic [2:0] row, col, rd_row, rd_col;
  logic [1:0] piece, rd_data, winner;
  logic       busy, done, win, draw;

  logic [1:0] board [0:5][0:6];
  int tests = 0;
  int fails = 0;
  int col6_cnt = 0;
  int bad_col = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  con4_win_checker #(.ROWS(6), .COLS(7), .WIN_LEN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .row(row), .col(col), .piece(piece),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .done(done), .win(win), .draw(draw), .winner(winner)
  );

  always @(posedge clk)
    rd_data <= (rd_row < 3'd6 && rd_col < 3'd7) ? board[rd_row][rd_col] : 2'b00;

  always @(negedge clk)
    if (mon_en) begin
      if (rd_col > 3'd6) bad_col++;
      if (rd_col == 3'd6 && rd_row >= 3'd3) col6_cnt++;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        board[r][c] = 2'b00;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    clear_board();
  endtask

  // lat = number of active edges from the one sampling start until done is seen.
  task automatic run(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p,
                     output int lat, output logic b1);
    @(negedge clk); row = r; col = c; piece = p; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; b1 = busy; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic watch(input int n, output logic sb, output logic sd);
    sb = 1'b0; sd = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (busy) sb = 1'b1;
      if (done) sd = 1'b1;
    end
  endtask

  initial begin
    int lat, n, wins_seen, maxlat;
    logic b1, sb, sd;
    logic [1:0] p;
    rst = 1'b0; clear = 1'b0; start = 1'b0; row = 3'd0; col = 3'd0; piece = 2'b00;
    clear_board();
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_win", win, 0);
    check("rst_draw", draw, 0);
    check("rst_winner", winner, 0);
    check("rst_rd_addr", {rd_row, rd_col}, 0);
    @(negedge clk); rst = 1'b1;

    // Lone piece on an empty board.
    board[5][3] = 2'b01;
    run(3'd5, 3'd3, 2'b01, lat, b1);
    check("empty_busy_on_start", b1, 1);
    check("empty_latency", lat, 19);
    check("empty_busy_at_done", busy, 0);
    check("empty_win", win, 0);
    check("empty_draw", draw, 0);
    check("empty_winner", winner, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    // Horizontal win on the bottom row, then start is ignored.
    do_clear();
    check("clear_after_scan_win", win, 0);
    for (int c = 0; c < 4; c++) board[5][c] = 2'b01;
    run(3'd5, 3'd3, 2'b01, lat, b1);
    check("horiz_latency", lat, 11);
    check("horiz_win", win, 1);
    check("horiz_winner", winner, 1);
    check("horiz_draw", draw, 0);
    @(negedge clk); row = 3'd4; col = 3'd0; piece = 2'b10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("ignored_busy", busy, 0);
    watch(20, sb, sd);
    check("ignored_no_busy", sb, 0);
    check("ignored_no_done", sd, 0);

    // Vertical win in the last column.
    do_clear();
    check("clear_win", win, 0);
    check("clear_winner", winner, 0);
    for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
    col6_cnt = 0; bad_col = 0; mon_en = 1'b1;
    run(3'd2, 3'd6, 2'b10, lat, b1);
    mon_en = 1'b0;
    check("vert_latency", lat, 13);
    check("vert_win", win, 1);
    check("vert_winner", winner, 2);
    check("vert_col_in_range", bad_col, 0);
    check("vert_col6_reads", col6_cnt, 6);

    // Anti-diagonal split: two below-left, one above-right.
    do_clear();
    board[5][0] = 2'b01; board[4][1] = 2'b01; board[2][3] = 2'b01; board[3][2] = 2'b01;
    run(3'd3, 3'd2, 2'b01, lat, b1);
    check("anti_latency", lat, 25);
    check("anti_win", win, 1);
    check("anti_winner", winner, 1);

    // Full board without any line of four; one malformed start mixed in.
    do_clear();
    n = 0; wins_seen = 0; maxlat = 0;
    for (int r = 5; r >= 0; r--)
      for (int c = 0; c < 7; c++) begin
        p = ((((c >> 1) + r) % 2) != 0) ? 2'b10 : 2'b01;
        board[r][c] = p;
        run(3'(r), 3'(c), p, lat, b1);
        n++;
        if (win) wins_seen++;
        if (lat > maxlat) maxlat = lat;
        if (n == 20) begin
          run(3'd6, 3'd0, 2'b01, lat, b1);
          check("malformed_row_latency", lat, 2);
        end
        if (n == 41) check("no_draw_at_41", draw, 0);
      end
    check("fill_no_win", wins_seen, 0);
    check("fill_latency_bound", maxlat <= 62, 1);
    check("draw_set", draw, 1);
    check("draw_no_win", win, 0);
    check("draw_winner", winner, 0);
    do_clear();
    check("clear_draw", draw, 0);
    board[5][3] = 2'b01;
    run(3'd5, 3'd3, 2'b01, lat, b1);
    check("counter_cleared_no_draw", draw, 0);

    // Piece value 00 is malformed.
    run(3'd4, 3'd3, 2'b00, lat, b1);
    check("malformed_piece_latency", lat, 2);
    check("malformed_piece_win", win, 0);
    check("malformed_piece_draw", draw, 0);

    // clear and start on the same edge: start is dropped.
    @(negedge clk); clear = 1'b1; start = 1'b1; row = 3'd5; col = 3'd3; piece = 2'b01;
    @(posedge clk); #1;
    check("clear_vs_start_busy", busy, 0);
    @(negedge clk); clear = 1'b0; start = 1'b0;
    watch(5, sb, sd);
    check("clear_vs_start_idle", sb, 0);

    // clear mid-scan: abort with no done.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    check("midscan_clear_busy", busy, 0);
    @(negedge clk); clear = 1'b0;
    watch(30, sb, sd);
    check("midscan_clear_no_done", sd, 0);

    // Asynchronous reset during CMP of cell (5,4).
    @(negedge clk); start = 1'b1; row = 3'd5; col = 3'd3; piece = 2'b01;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("cmp_rd_addr", {rd_row, rd_col}, {3'd5, 3'd4});
    check("cmp_busy", busy, 1);
    rst = 1'b0; #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_addr", {rd_row, rd_col}, 0);
    @(negedge clk); rst = 1'b1;
    watch(30, sb, sd);
    check("async_rst_no_done", sd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
